// File: rtl/rom_arb_pkg.sv
// ----------------------------------------------------------------------------
// rom_arb_pkg
// Shared definitions for the three-reader image-ROM arbiter.
//   PORT_DISP / PORT_COLL / PORT_MENU : bit positions of each reader in the
//                                       req/gnt/rvalid vectors
//   NUM_PORTS                         : number of readers
//   port_onehot_t                     : one-hot grant/tag vector type
//   GNT_*                             : the legal one-hot grant encodings
// ----------------------------------------------------------------------------
package rom_arb_pkg;

    localparam int PORT_DISP = 0;
    localparam int PORT_COLL = 1;
    localparam int PORT_MENU = 2;
    localparam int NUM_PORTS = 3;

    typedef logic [2:0] port_onehot_t;

    localparam port_onehot_t GNT_NONE = 3'b000;
    localparam port_onehot_t GNT_DISP = 3'b001;
    localparam port_onehot_t GNT_COLL = 3'b010;
    localparam port_onehot_t GNT_MENU = 3'b100;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// rom_port_arbiter_if
// Bundles the requester handshake and the ROM-side signals of the arbiter.
//   req[2:0]            : per-reader read request (0 display, 1 collision, 2 menu)
//   addr0/addr1/addr2   : per-reader read address, valid while its req bit is high
//   gnt[2:0]            : one-hot grant, same cycle as the accepted request
//   rom_address         : address presented to the ROM
//   rom_q               : ROM read data
//   rdata / rvalid[2:0] : returned data and one-hot owner tag
// Modports: master = readers plus ROM model, slave = arbiter.
// ----------------------------------------------------------------------------
interface rom_port_arbiter_if
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 3
);
    port_onehot_t      req;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    port_onehot_t      gnt;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_q;
    logic [DATA_W-1:0] rdata;
    port_onehot_t      rvalid;

    modport master (
        output req, addr0, addr1, addr2, rom_q,
        input  gnt, rom_address, rdata, rvalid
    );

    modport slave (
        input  req, addr0, addr1, addr2, rom_q,
        output gnt, rom_address, rdata, rvalid
    );

endinterface

// File: rtl/rom_tag_pipe.sv
// ----------------------------------------------------------------------------
// rom_tag_pipe
// Delay line for one-hot grant tags so each tag emerges exactly DEPTH cycles
// after it entered, aligned with the ROM's registered read data.
//   clk     : clock
//   reset   : synchronous active-high reset, empties the line
//   tag_in  : one-hot tag of the grant issued this cycle
//   tag_out : one-hot tag of the grant issued DEPTH cycles ago
// ----------------------------------------------------------------------------
module rom_tag_pipe
    import rom_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  port_onehot_t tag_in,
    output port_onehot_t tag_out
);

    port_onehot_t chain_r [DEPTH];

    // Shift tags one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                chain_r[i] <= GNT_NONE;
            end
        end else begin
            chain_r[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                chain_r[i] <= chain_r[i-1];
            end
        end
    end

    assign tag_out = chain_r[DEPTH-1];

endmodule

// File: rtl/rom_port_arbiter.sv
// ----------------------------------------------------------------------------
// rom_port_arbiter
// Shares one registered-output image ROM between the display renderer
// (port 0, strict priority), the collision engine (port 1) and the menu
// cursor hit-test (port 2). Ports 1 and 2 alternate via a round-robin bit.
// Read data returns ROM_LAT cycles after the grant, tagged one-hot on rvalid.
//   vga_clk        : single clock
//   reset          : synchronous active-high reset
//   bus (slave)    : req/addrN/gnt/rom_address/rom_q/rdata/rvalid
//   stat_conflicts : cycles in which a secondary request was denied
//   stat_maxwait   : longest wait seen by any secondary request
// Optional build macro ROM_ARB_STATS_EN adds the two statistics ports.
// ----------------------------------------------------------------------------
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 3,
    parameter int ROM_LAT = 1,
    parameter int STAT_W  = 16
) (
    input  logic                vga_clk,
    input  logic                reset,
    rom_port_arbiter_if.slave   bus
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat_conflicts,
    output logic [STAT_W-1:0]   stat_maxwait
`endif
);

    port_onehot_t      gnt_s;
    logic [ADDR_W-1:0] rom_address_s;
    logic              rr_r;           // 0 favours collision, 1 favours menu
    logic [ADDR_W-1:0] last_addr_r;
    port_onehot_t      tag_out_s;

    // Display first; secondaries contend only when both request.
    always_comb begin
        gnt_s = GNT_NONE;
        if (bus.req[PORT_DISP]) begin
            gnt_s = GNT_DISP;
        end else if (bus.req[PORT_COLL] && bus.req[PORT_MENU]) begin
            gnt_s = rr_r ? GNT_MENU : GNT_COLL;
        end else if (bus.req[PORT_COLL]) begin
            gnt_s = GNT_COLL;
        end else if (bus.req[PORT_MENU]) begin
            gnt_s = GNT_MENU;
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    // Steer the granted address to the ROM; idle cycles repeat the last one.
    always_comb begin
        rom_address_s = last_addr_r;
        case (gnt_s)
            GNT_DISP: rom_address_s = bus.addr0;
            GNT_COLL: rom_address_s = bus.addr1;
            GNT_MENU: rom_address_s = bus.addr2;
            default:  rom_address_s = last_addr_r;
        endcase
    end

    // Round-robin pointer and held ROM address.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rr_r        <= 1'b0;
            last_addr_r <= {ADDR_W{1'b0}};
        end else begin
            if (gnt_s == GNT_COLL) begin
                rr_r <= 1'b1;
            end else if (gnt_s == GNT_MENU) begin
                rr_r <= 1'b0;
            end else begin
                rr_r <= rr_r;
            end
            last_addr_r <= rom_address_s;
        end
    end

    rom_tag_pipe #(
        .DEPTH   (ROM_LAT)
    ) u_tag_pipe (
        .clk     (vga_clk),
        .reset   (reset),
        .tag_in  (gnt_s),
        .tag_out (tag_out_s)
    );

    assign bus.gnt         = gnt_s;
    assign bus.rom_address = rom_address_s;
    assign bus.rvalid      = tag_out_s;
    assign bus.rdata       = bus.rom_q;

`ifdef ROM_ARB_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == STAT_MAX) ? v : v + STAT_ONE;
    endfunction

    logic [STAT_W-1:0] conflicts_r;
    logic [STAT_W-1:0] maxwait_r;
    logic [STAT_W-1:0] wait_coll_r;
    logic [STAT_W-1:0] wait_menu_r;
    logic              denied_s;

    // At most one cycle counted even if both secondaries are refused.
    assign denied_s = (bus.req[PORT_COLL] && !gnt_s[PORT_COLL]) ||
                      (bus.req[PORT_MENU] && !gnt_s[PORT_MENU]);

    // Conflict count, per-secondary wait timers and the worst wait so far.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            conflicts_r <= {STAT_W{1'b0}};
            maxwait_r   <= {STAT_W{1'b0}};
            wait_coll_r <= {STAT_W{1'b0}};
            wait_menu_r <= {STAT_W{1'b0}};
        end else begin
            conflicts_r <= denied_s ? sat_inc(conflicts_r) : conflicts_r;

            if (gnt_s[PORT_COLL]) begin
                wait_coll_r <= {STAT_W{1'b0}};
            end else if (bus.req[PORT_COLL]) begin
                wait_coll_r <= sat_inc(wait_coll_r);
            end else begin
                wait_coll_r <= wait_coll_r;
            end

            if (gnt_s[PORT_MENU]) begin
                wait_menu_r <= {STAT_W{1'b0}};
            end else if (bus.req[PORT_MENU]) begin
                wait_menu_r <= sat_inc(wait_menu_r);
            end else begin
                wait_menu_r <= wait_menu_r;
            end

            if (gnt_s[PORT_COLL] && (wait_coll_r > maxwait_r)) begin
                maxwait_r <= wait_coll_r;
            end else if (gnt_s[PORT_MENU] && (wait_menu_r > maxwait_r)) begin
                maxwait_r <= wait_menu_r;
            end else begin
                maxwait_r <= maxwait_r;
            end
        end
    end

    assign stat_conflicts = conflicts_r;
    assign stat_maxwait   = maxwait_r;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rom_port_arbiter
// Drives three arbiter instances (ROM_LAT = 1, 2, 3) with identical request
// traffic, each with its own registered ROM model, and compares them every
// cycle against a behavioural model: grant rules, address steering, and the
// per-cycle history of issued reads replayed ROM_LAT cycles later.
// Directed sequences pin the model with literal expectations, followed by a
// randomized phase honouring the hold-until-granted handshake.
// ----------------------------------------------------------------------------
module tb_rom_port_arbiter;
    import rom_arb_pkg::*;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 3;
    localparam int STAT_W = 16;
    localparam int NI     = 3;

    logic              vga_clk = 1'b0;
    logic              reset   = 1'b1;
    port_onehot_t      req     = 3'b000;
    logic [ADDR_W-1:0] addr0   = 17'h0;
    logic [ADDR_W-1:0] addr1   = 17'h0;
    logic [ADDR_W-1:0] addr2   = 17'h0;

    logic [NI-1:0][2:0]        gnt_a;
    logic [NI-1:0][2:0]        rvalid_a;
    logic [NI-1:0][DATA_W-1:0] rdata_a;
    logic [NI-1:0][ADDR_W-1:0] radr_a;
`ifdef ROM_ARB_STATS_EN
    logic [NI-1:0][STAT_W-1:0] sc_a;
    logic [NI-1:0][STAT_W-1:0] sm_a;
`endif

    int checks = 0;
    int errors = 0;

    always #5 vga_clk = ~vga_clk;

    function automatic logic [DATA_W-1:0] romf(input logic [ADDR_W-1:0] a);
        return a[2:0] ^ a[5:3] ^ a[8:6] ^ a[16:14];
    endfunction

    for (genvar k = 0; k < NI; k++) begin : g_inst
        rom_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
        logic [DATA_W-1:0] rom_pipe [0:k];

        assign bus.req   = req;
        assign bus.addr0 = addr0;
        assign bus.addr1 = addr1;
        assign bus.addr2 = addr2;
        assign bus.rom_q = rom_pipe[k];

        always @(posedge vga_clk) begin
            rom_pipe[0] <= romf(bus.rom_address);
            for (int j = 1; j <= k; j++) rom_pipe[j] <= rom_pipe[j-1];
        end

        assign gnt_a[k]    = bus.gnt;
        assign rvalid_a[k] = bus.rvalid;
        assign rdata_a[k]  = bus.rdata;
        assign radr_a[k]   = bus.rom_address;

        rom_port_arbiter #(
            .ADDR_W (ADDR_W), .DATA_W (DATA_W), .ROM_LAT (k + 1), .STAT_W (STAT_W)
        ) dut (
            .vga_clk (vga_clk),
            .reset   (reset),
            .bus     (bus)
`ifdef ROM_ARB_STATS_EN
            ,
            .stat_conflicts (sc_a[k]),
            .stat_maxwait   (sm_a[k])
`endif
        );
    end

    // ---------------- behavioural model state ----------------
    logic              rr_m        = 1'b0;
    logic [ADDR_W-1:0] last_addr_m = 17'h0;
    port_onehot_t      hist_g [8];
    logic [ADDR_W-1:0] hist_a [8];
    int                cyc     = 0;
    logic              started = 1'b0;
    port_onehot_t      last_g  = 3'b000;
    int                conf_m  = 0;
    int                maxw_m  = 0;
    int                w1_m    = 0;
    int                w2_m    = 0;

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp);
        end
    endtask

    // Called at the negedge: compare all instances to the model, advance the
    // model by one cycle, then return just after the next rising edge.
    task automatic tick();
        port_onehot_t      eg;
        port_onehot_t      ev;
        logic [ADDR_W-1:0] ea;
        int                idx;
        if (req[0])               eg = 3'b001;
        else if (req[1] && req[2]) eg = rr_m ? 3'b100 : 3'b010;
        else if (req[1])          eg = 3'b010;
        else if (req[2])          eg = 3'b100;
        else                      eg = 3'b000;
        case (eg)
            3'b001:  ea = addr0;
            3'b010:  ea = addr1;
            3'b100:  ea = addr2;
            default: ea = last_addr_m;
        endcase
        if (started) begin
            for (int k = 0; k < NI; k++) begin
                chk("gnt", k, gnt_a[k], eg);
                chk("rom_address", k, radr_a[k], ea);
                ev = 3'b000;
                idx = 0;
                if (cyc >= k + 1) begin
                    idx = (cyc - (k + 1)) % 8;
                    ev  = hist_g[idx];
                end
                chk("rvalid", k, rvalid_a[k], ev);
                if (ev != 3'b000) chk("rdata", k, rdata_a[k], romf(hist_a[idx]));
            end
`ifdef ROM_ARB_STATS_EN
            chk("stat_conflicts", 0, sc_a[0], conf_m);
            chk("stat_maxwait", 0, sm_a[0], maxw_m);
`endif
        end
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                hist_g[i] = 3'b000;
                hist_a[i] = 17'h0;
            end
            rr_m = 1'b0;
            last_addr_m = 17'h0;
            conf_m = 0; maxw_m = 0; w1_m = 0; w2_m = 0;
            started = 1'b1;
        end else begin
            hist_g[cyc % 8] = eg;
            hist_a[cyc % 8] = ea;
            if (eg != 3'b000) last_addr_m = ea;
            if (eg == 3'b010) rr_m = 1'b1;
            if (eg == 3'b100) rr_m = 1'b0;
            if ((req[1] && !eg[1]) || (req[2] && !eg[2])) conf_m++;
            if (eg[1]) begin
                if (w1_m > maxw_m) maxw_m = w1_m;
                w1_m = 0;
            end else if (req[1]) w1_m++;
            if (eg[2]) begin
                if (w2_m > maxw_m) maxw_m = w2_m;
                w2_m = 0;
            end else if (req[2]) w2_m++;
        end
        last_g = eg;
        cyc++;
        @(posedge vga_clk);
        #1;
    endtask

    port_onehot_t exp_seq [3];
    logic [DATA_W-1:0] exp_dat [3];
    logic disp_mode;

    initial begin
        // ---- reset ----
        reset = 1'b1;
        req   = 3'b000;
        @(posedge vga_clk); #1;
        repeat (2) begin @(negedge vga_clk); tick(); end
        reset = 1'b0;
        @(negedge vga_clk);
        for (int k = 0; k < NI; k++) chk("reset_rvalid", k, rvalid_a[k], 3'b000);
        tick();

        // ---- single collision read, ROM_LAT=1 ----
        req = 3'b010; addr1 = 17'h00010;
        @(negedge vga_clk);
        chk("t1_gnt", 0, gnt_a[0], 3'b010);
        chk("t1_addr", 0, radr_a[0], 17'h00010);
        tick();
        req = 3'b000;
        @(negedge vga_clk);
        chk("t1_rvalid", 0, rvalid_a[0], 3'b010);
        chk("t1_rdata", 0, rdata_a[0], 3'd2);
        tick();

        // menu alone brings rr back to collision
        req = 3'b100; addr2 = 17'h00030;
        @(negedge vga_clk);
        chk("menu_alone", 0, gnt_a[0], 3'b100);
        tick();

        // ---- all three, then display drops ----
        req = 3'b111; addr0 = 17'h00100;
        repeat (4) begin
            @(negedge vga_clk);
            chk("t2_disp", 0, gnt_a[0], 3'b001);
            tick();
        end
        req = 3'b110;
        exp_seq[0] = 3'b010; exp_seq[1] = 3'b100; exp_seq[2] = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(negedge vga_clk);
            chk("t2_rr", i, gnt_a[0], exp_seq[i]);
            tick();
        end
        req = 3'b100;
        @(negedge vga_clk);
        chk("t2_menu", 0, gnt_a[0], 3'b100);
        tick();

        // ---- round robin with rr=0, then menu alone ----
        req = 3'b110;
        @(negedge vga_clk); chk("t3_first", 0, gnt_a[0], 3'b010); tick();
        @(negedge vga_clk); chk("t3_second", 0, gnt_a[0], 3'b100); tick();
        req = 3'b100;
        repeat (3) begin
            @(negedge vga_clk); chk("t3_menu", 0, gnt_a[0], 3'b100); tick();
        end

        // ---- ROM_LAT=3 ordering ----
        req = 3'b001; addr0 = 17'h00001; @(negedge vga_clk); tick();
        req = 3'b010; addr1 = 17'h00002; @(negedge vga_clk); tick();
        req = 3'b100; addr2 = 17'h04005; @(negedge vga_clk); tick();
        req = 3'b000;
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100;
        exp_dat[0] = 3'd1;   exp_dat[1] = 3'd2;   exp_dat[2] = 3'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge vga_clk);
            chk("t4_rvalid", i, rvalid_a[2], exp_seq[i]);
            chk("t4_rdata", i, rdata_a[2], exp_dat[i]);
            tick();
        end
        @(negedge vga_clk); chk("t4_idle", 0, rvalid_a[2], 3'b000); tick();

        // ---- reset kills an in-flight ROM_LAT=2 read ----
        req = 3'b010; addr1 = 17'h1ABCD;
        @(negedge vga_clk); chk("t5_gnt", 0, gnt_a[1], 3'b010); tick();
        reset = 1'b1; req = 3'b000;
        @(negedge vga_clk); chk("t5_rv_a", 1, rvalid_a[1], 3'b000); tick();
        reset = 1'b0; req = 3'b100; addr2 = 17'h00777;
        @(negedge vga_clk);
        chk("t5_rv_b", 1, rvalid_a[1], 3'b000);
        chk("t5_menu", 1, gnt_a[1], 3'b100);
        tick();
        req = 3'b000;
        @(negedge vga_clk); chk("t5_rv_c", 1, rvalid_a[1], 3'b000); tick();

`ifdef ROM_ARB_STATS_EN
        // ---- statistics: collision starved for five cycles ----
        reset = 1'b1; @(negedge vga_clk); tick();
        reset = 1'b0;
        req = 3'b011; addr0 = 17'h00200; addr1 = 17'h00300;
        repeat (5) begin @(negedge vga_clk); tick(); end
        req = 3'b010;
        @(negedge vga_clk); chk("t6_gnt", 0, gnt_a[0], 3'b010); tick();
        req = 3'b000;
        @(negedge vga_clk);
        chk("t6_conflicts", 0, sc_a[0], 32'd5);
        chk("t6_maxwait", 0, sm_a[0], 32'd5);
        tick();
`endif

        // ---- randomized traffic with hold-until-granted requesters ----
        disp_mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) disp_mode = ~disp_mode;
            if (!(req[0] && !last_g[0])) begin
                req[0] = disp_mode ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
                addr0  = 17'($urandom);
            end
            if (!(req[1] && !last_g[1])) begin
                req[1] = ($urandom_range(0, 1) == 0);
                addr1  = 17'($urandom);
            end
            if (!(req[2] && !last_g[2])) begin
                req[2] = ($urandom_range(0, 1) == 0);
                addr2  = 17'($urandom);
            end
            reset = ($urandom_range(0, 99) == 0);
            @(negedge vga_clk);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
